// File: rtl/full_subtractor_pkg.sv
// Shared constants and the 1-bit subtract reference
// for the registered full subtractor.
package full_subtractor_pkg;

  localparam int DEF_WIDTH = 1;

  // Returns {borrow_out, diff} for one bit position.
  function automatic logic [1:0] fs_bit(
    input logic a,
    input logic b,
    input logic bin
  );
    logic d;
    logic bo;
    d  = a ^ b ^ bin;
    bo = (~a & b) | (~(a ^ b) & bin);
    return {bo, d};
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit combinational full subtractor cell.
// Used as a link in the ripple-borrow chain.
module full_subtractor_cell
  import full_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow from the shared bit function.
  always_comb begin
    {bout, d} = fs_bit(a, b, bin);
  end

endmodule

// File: rtl/full_subtractor_unit.sv
// Registered WIDTH-bit ripple-borrow subtractor:
// {bout, D} = a - b - bin, one cycle latency.
module full_subtractor_unit
  import full_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] d;

  assign c[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (c[i]),
      .d    (d[i]),
      .bout (c[i+1])
    );
  end

  // Capture result on accepted operands; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      D         <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        D    <= d;
        bout <= c[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor_unit.sv
// Directed and random checks for full_subtractor_unit
// at WIDTH=1 and WIDTH=8.
module tb_full_subtractor_unit;

  logic       clk;
  logic       rst;

  logic       v1, a1, b1, bi1;
  logic       d1, bo1, ov1;

  logic       v8, bi8;
  logic [7:0] a8, b8;
  logic [7:0] d8;
  logic       bo8, ov8;

  int checks;
  int failures;

  typedef struct {
    logic a;
    logic b;
    logic bin;
    logic d;
    logic bout;
  } vec1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bout;
  } vec8_t;

  vec1_t tv1 [8];
  vec8_t tv8 [2];

  full_subtractor_unit #(.WIDTH(1)) u_w1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v1),
    .a         (a1),
    .b         (b1),
    .bin       (bi1),
    .D         (d1),
    .bout      (bo1),
    .out_valid (ov1)
  );

  full_subtractor_unit #(.WIDTH(8)) u_w8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v8),
    .a         (a8),
    .b         (b8),
    .bin       (bi8),
    .D         (d8),
    .bout      (bo8),
    .out_valid (ov8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  initial begin
    logic [8:0] r;
    logic [7:0] ra, rb;
    logic       rbi;

    checks   = 0;
    failures = 0;

    tv1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tv1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tv1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tv1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tv1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tv1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    tv8[0] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    tv8[1] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};

    rst = 1'b1;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;
    v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bi8 = 1'b0;

    #1;
    check("rst_d1", 32'(d1), 32'd0);
    check("rst_ov1", 32'(ov1), 32'd0);
    check("rst_d8", 32'(d8), 32'd0);
    check("rst_ov8", 32'(ov8), 32'd0);

    @(negedge clk);
    rst = 1'b0;

    // Exhaustive 1-bit truth table, back-to-back.
    for (int i = 0; i < 8; i++) begin
      v1  = 1'b1;
      a1  = tv1[i].a;
      b1  = tv1[i].b;
      bi1 = tv1[i].bin;
      @(posedge clk);
      #1;
      check($sformatf("w1_d_%0d", i), 32'(d1), 32'(tv1[i].d));
      check($sformatf("w1_bo_%0d", i), 32'(bo1), 32'(tv1[i].bout));
      check($sformatf("w1_ov_%0d", i), 32'(ov1), 32'd1);
      @(negedge clk);
    end

    // Hold: load D=1, then idle with changed inputs.
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bi1 = 1'b0;
    @(posedge clk);
    #1;
    check("hold_load_d", 32'(d1), 32'd1);
    check("hold_load_bo", 32'(bo1), 32'd0);
    @(negedge clk);
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b1; bi1 = 1'b1;
    @(posedge clk);
    #1;
    check("hold_d", 32'(d1), 32'd1);
    check("hold_bo", 32'(bo1), 32'd0);
    check("hold_ov", 32'(ov1), 32'd0);

    // Mid-stream async reset with D=1.
    @(negedge clk);
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bi1 = 1'b0;
    @(posedge clk);
    #1;
    check("mid_pre_d", 32'(d1), 32'd1);
    check("mid_pre_ov", 32'(ov1), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_d", 32'(d1), 32'd0);
    check("mid_rst_bo", 32'(bo1), 32'd0);
    check("mid_rst_ov", 32'(ov1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    a1 = 1'b1; b1 = 1'b1; bi1 = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_d", 32'(d1), 32'd1);
    check("post_rst_bo", 32'(bo1), 32'd1);
    check("post_rst_ov", 32'(ov1), 32'd1);
    @(negedge clk);
    v1 = 1'b0;

    // 8-bit borrow ripple corners.
    for (int i = 0; i < 2; i++) begin
      v8  = 1'b1;
      a8  = tv8[i].a;
      b8  = tv8[i].b;
      bi8 = tv8[i].bin;
      @(posedge clk);
      #1;
      check($sformatf("w8_d_%0d", i), 32'(d8), 32'(tv8[i].d));
      check($sformatf("w8_bo_%0d", i), 32'(bo8), 32'(tv8[i].bout));
      check($sformatf("w8_ov_%0d", i), 32'(ov8), 32'd1);
      @(negedge clk);
    end

    // 8-bit random, back-to-back.
    for (int i = 0; i < 1000; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rbi = 1'($urandom_range(0, 1));
      v8  = 1'b1;
      a8  = ra;
      b8  = rb;
      bi8 = rbi;
      r   = {1'b0, ra} - {1'b0, rb} - {8'h00, rbi};
      @(posedge clk);
      #1;
      check($sformatf("rnd_%0d", i),
            {23'd0, ov8, bo8, d8},
            {23'd0, 1'b1, r[8], r[7:0]});
      @(negedge clk);
    end
    v8 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
